// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver running at OVERSAMPLE clocks per bit. It has a two-flop input
// synchroniser, a start-bit check at mid-bit that rejects glitches, optional
// odd/even parity, stop-bit checking with break hold-off, and a show-ahead
// receive FIFO that the CPU drains with RX_READ.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : asynchronous, active-high, clears all state
//   UART_RX        : asynchronous serial line, idle high, LSB first
//   RX_READ        : pop strobe, ignored while RX_VALID is 0
//   RX_DATA        : FIFO head (show-ahead), 0 when the FIFO is empty
//   RX_VALID       : FIFO non-empty
//   RX_COUNT       : FIFO occupancy
//   RX_PARITY_ERR  : 1-cycle pulse, parity mismatch (frame dropped)
//   RX_FRAME_ERR   : 1-cycle pulse, stop bit sampled low (frame dropped)
//   RX_OVERRUN     : 1-cycle pulse, good frame dropped because the FIFO is full
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       UART_RX,
    input  logic                       RX_READ,
    output logic [DATA_BITS-1:0]       RX_DATA,
    output logic                       RX_VALID,
    output logic [$clog2(DEPTH):0]     RX_COUNT,
    output logic                       RX_PARITY_ERR,
    output logic                       RX_FRAME_ERR,
    output logic                       RX_OVERRUN
);

    localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W   = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    // START is entered with cnt=0 one edge after rx_s went low; the centre of
    // the start bit lies OVERSAMPLE/2-1 edges later, when cnt reads OVERSAMPLE/2-2.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic             ODD_P    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    // Receiver state
    logic                 r_sync1, r_sync2;
    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_sh, w_sh_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 w_frame_end;
    logic                 w_rx_s;

    // FIFO state
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr, w_rd_nxt;
    logic [OCC_W-1:0]     r_count, w_count_nxt;
    logic [DATA_BITS-1:0] r_data, w_head_nxt;
    logic                 r_valid;
    logic                 r_par_pulse, r_frm_pulse, r_ovr_pulse;
    logic                 w_push, w_pop, w_full, w_push_acc;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser, idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx_s) w_state_nxt = S_START;
            S_START: if (r_cnt == CNT_HALF) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (r_cnt == CNT_LAST && r_idx == IDX_LAST)
                         w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (r_cnt == CNT_LAST) w_state_nxt = S_STOP;
            S_STOP:  if (r_cnt == CNT_LAST) w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rx_s) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: bit timing, shift register, parity and frame-end strobe
    always_comb begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_perr_nxt  = r_perr;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_idx_nxt  = '0;
                w_perr_nxt = 1'b0;
            end
            S_START: if (r_cnt == CNT_HALF) w_cnt_nxt = '0;
            S_DATA: if (r_cnt == CNT_LAST) begin
                // LSB first: after DATA_BITS right shifts bit k sits at index k
                w_cnt_nxt = '0;
                w_sh_nxt  = {w_rx_s, r_sh[DATA_BITS-1:1]};
                w_idx_nxt = r_idx + IDX_W'(1);
            end
            S_PAR: if (r_cnt == CNT_LAST) begin
                w_cnt_nxt  = '0;
                w_perr_nxt = (((^r_sh) ^ w_rx_s) != ODD_P);
            end
            S_STOP: if (r_cnt == CNT_LAST) begin
                w_cnt_nxt   = '0;
                w_frame_end = 1'b1;
            end
            S_BREAK: w_cnt_nxt = '0;
            default: w_cnt_nxt = '0;
        endcase
    end

    // Receiver datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_sh   <= '0;
            r_perr <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_sh   <= w_sh_nxt;
            r_perr <= w_perr_nxt;
        end
    end

    // FIFO control; a push into a full FIFO is still accepted if a pop frees a slot
    assign w_push     = w_frame_end & w_rx_s & ~r_perr;
    assign w_full     = (r_count == OCC_FULL);
    assign w_pop      = RX_READ & (r_count != '0);
    assign w_push_acc = w_push & (~w_full | w_pop);
    assign w_rd_nxt   = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop})
            2'b10:   w_count_nxt = r_count + OCC_W'(1);
            2'b01:   w_count_nxt = r_count - OCC_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next head: the slot being written this cycle becomes the head when the
    // FIFO is (or becomes) otherwise empty, so bypass the memory read
    always_comb begin
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_count_nxt == '0)
            w_head_nxt = '0;
        else if (w_push_acc && (w_rd_nxt == r_wr_ptr))
            w_head_nxt = r_sh;
    end

    // FIFO storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push_acc) begin
            r_mem[r_wr_ptr] <= r_sh;
        end
    end

    // FIFO pointers, occupancy and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_par_pulse <= 1'b0;
            r_frm_pulse <= 1'b0;
            r_ovr_pulse <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_data      <= w_head_nxt;
            r_valid     <= (w_count_nxt != '0);
            r_par_pulse <= w_frame_end & w_rx_s & r_perr;
            r_frm_pulse <= w_frame_end & ~w_rx_s;
            r_ovr_pulse <= w_push & w_full & ~w_pop;
        end
    end

    assign RX_DATA       = r_data;
    assign RX_VALID      = r_valid;
    assign RX_COUNT      = r_count;
    assign RX_PARITY_ERR = r_par_pulse;
    assign RX_FRAME_ERR  = r_frm_pulse;
    assign RX_OVERRUN    = r_ovr_pulse;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. dut0 is 8N1 and dut1 is 8E1, both 16 clk/bit with a
// 4-deep FIFO. Frames are serialised bit by bit onto the line, and a queue
// model of the receive FIFO plus error counters predicts what each DUT should
// show.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int OS    = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    // Line falls just after edge P0: rx_s low after P2, START at P3, stop
    // sampled OS/2-1 + (DB+1)*OS edges later, RX_VALID visible after that edge.
    localparam int EXP_LAT = 3 + OS / 2 - 1 + (DB + 1) * OS;

    logic clk = 1'b0;
    logic reset;
    logic rx0, rx1, rd0, rd1;
    logic [DB-1:0] d0, d1;
    logic v0, v1;
    logic [CW-1:0] c0, c1;
    logic pe0, fe0, ov0, pe1, fe1, ov1;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(0), .DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(reset), .UART_RX(rx0), .RX_READ(rd0),
        .RX_DATA(d0), .RX_VALID(v0), .RX_COUNT(c0),
        .RX_PARITY_ERR(pe0), .RX_FRAME_ERR(fe0), .RX_OVERRUN(ov0));

    uart_rx_fifo #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY(2), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .UART_RX(rx1), .RX_READ(rd1),
        .RX_DATA(d1), .RX_VALID(v1), .RX_COUNT(c1),
        .RX_PARITY_ERR(pe1), .RX_FRAME_ERR(fe1), .RX_OVERRUN(ov1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int v0_rise = -1;
    logic v0_q  = 1'b0;
    int got_pe[2], got_fe[2], got_ov[2];
    int exp_pe[2], exp_fe[2], exp_ov[2];
    logic [DB-1:0] q0[$], q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and RX_VALID rise time of dut0, sampled mid-cycle
    always @(negedge clk) begin
        if (pe0) got_pe[0]++;
        if (fe0) got_fe[0]++;
        if (ov0) got_ov[0]++;
        if (pe1) got_pe[1]++;
        if (fe1) got_fe[1]++;
        if (ov1) got_ov[1]++;
        if (v0 && !v0_q) v0_rise = cyc;
        v0_q = v0;
    end

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx0 = b; else rx1 = b;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    // Serialise one frame and update the reference model with its outcome
    task automatic send_frame(input int sel, input logic [DB-1:0] data,
                              input logic bad_par, input logic stop_bit);
        logic p;
        int   sz;
        p = (^data) ^ bad_par;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < DB; i++) drive_bit(sel, data[i]);
        if (sel == 1) drive_bit(sel, p);
        drive_bit(sel, stop_bit);
        sz = (sel == 0) ? q0.size() : q1.size();
        if (!stop_bit)                exp_fe[sel]++;
        else if (sel == 1 && bad_par) exp_pe[sel]++;
        else if (sz == DEPTH)         exp_ov[sel]++;
        else if (sel == 0)            q0.push_back(data);
        else                          q1.push_back(data);
    endtask

    // Capture the shown head, pulse RX_READ for one cycle, pop the model
    task automatic pop(input int sel, output logic [DB-1:0] got, output logic [DB-1:0] exp);
        exp = '0;
        if (sel == 0) begin
            got = d0;
            if (q0.size() > 0) exp = q0.pop_front();
            rd0 = 1'b1;
        end else begin
            got = d1;
            if (q1.size() > 0) exp = q1.pop_front();
            rd1 = 1'b1;
        end
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({d0, v0, c0, pe0, fe0, ov0} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: data=%h valid=%b count=%0d pulses=%b%b%b, want all 0",
                     d0, v0, c0, pe0, fe0, ov0);
        end
        n_tests++;
        if ({d1, v1, c1, pe1, fe1, ov1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: data=%h valid=%b count=%0d pulses=%b%b%b, want all 0",
                     d1, v1, c1, pe1, fe1, ov1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [DB-1:0] g, e;
        int t0;
        t0 = cyc;
        v0_rise = -1;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        n_tests++;
        if (v0_rise - t0 !== EXP_LAT) begin
            n_fail++;
            $display("FAIL basic_latency: valid after %0d cycles, want %0d", v0_rise - t0, EXP_LAT);
        end
        n_tests++;
        if (v0 !== 1'b1 || d0 !== 8'hA5 || c0 !== CW'(q0.size())) begin
            n_fail++;
            $display("FAIL basic_rx: valid=%b data=%h count=%0d, want 1 a5 %0d", v0, d0, c0, q0.size());
        end
        pop(0, g, e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL basic_pop_data: got %h want %h", g, e);
        end
        n_tests++;
        if (v0 !== 1'b0 || d0 !== '0 || c0 !== '0) begin
            n_fail++;
            $display("FAIL basic_after_pop: valid=%b data=%h count=%0d, want 0 00 0", v0, d0, c0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] g, e;
        for (int i = 1; i <= 5; i++) send_frame(0, DB'(i), 1'b0, 1'b1);
        n_tests++;
        if (c0 !== CW'(q0.size()) || c0 !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL b2b_count: count=%0d want %0d", c0, DEPTH);
        end
        n_tests++;
        if (got_ov[0] !== exp_ov[0]) begin
            n_fail++;
            $display("FAIL b2b_overrun: pulses=%0d want %0d", got_ov[0], exp_ov[0]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            pop(0, g, e);
            n_tests++;
            if (g !== e || g !== DB'(i)) begin
                n_fail++;
                $display("FAIL b2b_read%0d: got %h want %h", i, g, e);
            end
        end
        n_tests++;
        if (v0 !== 1'b0 || c0 !== '0) begin
            n_fail++;
            $display("FAIL b2b_drained: valid=%b count=%0d, want 0 0", v0, c0);
        end
    endtask

    task automatic test_parity();
        logic [DB-1:0] g, e;
        send_frame(1, 8'h03, 1'b1, 1'b1);
        n_tests++;
        if (got_pe[1] !== exp_pe[1] || c1 !== '0) begin
            n_fail++;
            $display("FAIL parity_bad: pulses=%0d count=%0d, want %0d 0", got_pe[1], c1, exp_pe[1]);
        end
        send_frame(1, 8'h03, 1'b0, 1'b1);
        n_tests++;
        if (c1 !== 1 || d1 !== 8'h03 || got_pe[1] !== exp_pe[1]) begin
            n_fail++;
            $display("FAIL parity_good: count=%0d data=%h pulses=%0d, want 1 03 %0d",
                     c1, d1, got_pe[1], exp_pe[1]);
        end
        pop(1, g, e);
    endtask

    task automatic test_break();
        send_frame(0, 8'h55, 1'b0, 1'b0);
        repeat (40 * OS) @(posedge clk);
        #1;
        n_tests++;
        if (got_fe[0] !== exp_fe[0] || exp_fe[0] !== 1 || c0 !== '0 || v0 !== 1'b0) begin
            n_fail++;
            $display("FAIL break_frame_err: pulses=%0d count=%0d valid=%b, want 1 0 0",
                     got_fe[0], c0, v0);
        end
        rx0 = 1'b1;
        repeat (OS) @(posedge clk);
        #1;
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        n_tests++;
        if (c0 !== 1 || d0 !== 8'h3C || got_fe[0] !== exp_fe[0]) begin
            n_fail++;
            $display("FAIL break_recover: count=%0d data=%h fe=%0d, want 1 3c %0d",
                     c0, d0, got_fe[0], exp_fe[0]);
        end
        begin
            logic [DB-1:0] g, e;
            pop(0, g, e);
        end
    endtask

    task automatic test_glitch();
        rx0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx0 = 1'b1;
        repeat (2 * OS) @(posedge clk);
        #1;
        n_tests++;
        if (c0 !== '0 || got_fe[0] !== exp_fe[0] || got_pe[0] !== exp_pe[0] || got_ov[0] !== exp_ov[0]) begin
            n_fail++;
            $display("FAIL glitch_quiet: count=%0d fe=%0d pe=%0d ov=%0d", c0, got_fe[0], got_pe[0], got_ov[0]);
        end
        send_frame(0, 8'h96, 1'b0, 1'b1);
        n_tests++;
        if (c0 !== 1 || d0 !== 8'h96) begin
            n_fail++;
            $display("FAIL glitch_rearm: count=%0d data=%h, want 1 96", c0, d0);
        end
        begin
            logic [DB-1:0] g, e;
            pop(0, g, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] f;
        f = 8'hF0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        n_tests++;
        if (c0 !== 2 || d0 !== 8'h11) begin
            n_fail++;
            $display("FAIL rstmid_prefill: count=%0d data=%h, want 2 11", c0, d0);
        end
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, f[i]);
        rx0 = f[4];
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({d0, v0, c0, pe0, fe0, ov0} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: data=%h valid=%b count=%0d pulses=%b%b%b, want all 0",
                     d0, v0, c0, pe0, fe0, ov0);
        end
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rx0 = 1'b1;
        repeat (4 * OS) @(posedge clk);
        #1;
        send_frame(0, 8'h0F, 1'b0, 1'b1);
        n_tests++;
        if (c0 !== 1 || d0 !== 8'h0F || v0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_next: count=%0d data=%h valid=%b, want 1 0f 1", c0, d0, v0);
        end
        begin
            logic [DB-1:0] g, e;
            pop(0, g, e);
        end
    endtask

    task automatic test_random();
        logic [DB-1:0] g, e;
        for (int it = 0; it < 24; it++) begin
            int sel, gap, npop;
            logic bad_par, stop_bit;
            sel      = int'($urandom_range(0, 1));
            bad_par  = (sel == 1) && ($urandom_range(0, 5) == 0);
            stop_bit = ($urandom_range(0, 7) != 0);
            send_frame(sel, DB'($urandom), bad_par, stop_bit);
            if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
            gap = stop_bit ? int'($urandom_range(0, 2)) : 2;
            repeat (gap * OS) @(posedge clk);
            #1;
            npop = int'($urandom_range(0, 2));
            for (int k = 0; k < npop; k++) begin
                int ps;
                ps = int'($urandom_range(0, 1));
                pop(ps, g, e);
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rand_pop it%0d dut%0d: got %h want %h", it, ps, g, e);
                end
            end
            n_tests++;
            if (c0 !== CW'(q0.size()) || c1 !== CW'(q1.size())) begin
                n_fail++;
                $display("FAIL rand_count it%0d: counts %0d/%0d want %0d/%0d",
                         it, c0, c1, q0.size(), q1.size());
            end
        end
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if (got_pe[s] !== exp_pe[s] || got_fe[s] !== exp_fe[s] || got_ov[s] !== exp_ov[s]) begin
                n_fail++;
                $display("FAIL rand_pulses dut%0d: pe/fe/ov=%0d/%0d/%0d want %0d/%0d/%0d", s,
                         got_pe[s], got_fe[s], got_ov[s], exp_pe[s], exp_fe[s], exp_ov[s]);
            end
            while ((s == 0 ? q0.size() : q1.size()) > 0) begin
                pop(s, g, e);
                n_tests++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL rand_drain dut%0d: got %h want %h", s, g, e);
                end
            end
        end
        n_tests++;
        if (v0 !== 1'b0 || v1 !== 1'b0 || d0 !== '0 || d1 !== '0) begin
            n_fail++;
            $display("FAIL rand_empty: valid %b/%b data %h/%h, want 0/0 00/00", v0, v1, d0, d1);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            exp_pe[s] = 0; exp_fe[s] = 0; exp_ov[s] = 0;
            got_pe[s] = 0; got_fe[s] = 0; got_ov[s] = 0;
        end
        reset = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rd0 = 1'b0;
        rd1 = 1'b0;
        @(posedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_break();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
